wb_arbiter: RTL and testbench

- Writeback initiator for the 32x32 register file (x0 hard-wired zero, one write port).
- Arbitrates between two result producers, the single-cycle ALU and the multi-cycle load unit, using valid/ready handshakes.
- Registers the winning result onto the register-file write port.
- Keeps a pending-write scoreboard so issue logic can stall on RAW hazards.

---
 rtl/wb_arbiter.sv | 103 ++++++++++
 tb/tb_wb_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: grants ALU or load-unit results onto the register-file write port
// and tracks outstanding destination writes. Define WB_BYPASS_EN to add the same-cycle bypass port.
module wb_arbiter #(
   parameter bit FIXED_PRIO = 1'b0,
   parameter int XLEN       = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            mem_valid,
   output logic            mem_ready,
   input  logic [4:0]      mem_rd,
   input  logic [XLEN-1:0] mem_data,
   input  logic            issue_valid,
   input  logic [4:0]      issue_rd,
   output logic [4:0]      write_rg,
   output logic [XLEN-1:0] write_data,
`ifdef WB_BYPASS_EN
   input  logic [4:0]      byp_rg,
   output logic            byp_hit,
   output logic [XLEN-1:0] byp_data,
`endif
   output logic [31:0]     pend_mask
);

   typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;

   src_e            last_grant_q, last_grant_d;
   logic [4:0]      write_rg_q, write_rg_d;
   logic [XLEN-1:0] write_data_q, write_data_d;
   logic [31:0]     pend_q, pend_d;
   logic            alu_fire, mem_fire;

   // Grant: readies are held low throughout reset so nothing is consumed while it is asserted.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      alu_ready = 1'b0;
      mem_ready = 1'b0;
      if (rst) begin
         if (alu_valid && mem_valid) begin
            if (FIXED_PRIO || last_grant_q == SRC_ALU) mem_ready = 1'b1;
            else                                       alu_ready = 1'b1;
         end else begin
            alu_ready = alu_valid;
            mem_ready = mem_valid;
         end
      end
   end

   assign alu_fire = alu_valid && alu_ready;
   assign mem_fire = mem_valid && mem_ready;

   always_comb begin
      last_grant_d = last_grant_q;
      if (alu_valid && mem_valid) last_grant_d = alu_fire ? SRC_ALU : SRC_MEM;

      write_rg_d   = 5'd0;
      write_data_d = write_data_q;
      if (alu_fire) begin
         write_rg_d   = alu_rd;
         write_data_d = alu_data;
      end else if (mem_fire) begin
         write_rg_d   = mem_rd;
         write_data_d = mem_data;
      end

      // Clear before set so a reissue to the retiring register stays outstanding.
      pend_d = pend_q;
      if (alu_fire) pend_d[alu_rd] = 1'b0;
      if (mem_fire) pend_d[mem_rd] = 1'b0;
      if (issue_valid && issue_rd != 5'd0) pend_d[issue_rd] = 1'b1;
      pend_d[0] = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant_q <= SRC_MEM;
         write_rg_q   <= 5'd0;
         write_data_q <= '0;
         pend_q       <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         write_rg_q   <= write_rg_d;
         write_data_q <= write_data_d;
         pend_q       <= pend_d;
      end
   end

   assign write_rg   = write_rg_q;
   assign write_data = write_data_q;
   assign pend_mask  = pend_q;

`ifdef WB_BYPASS_EN
   // The register file has no write-through, so operand fetch reads the in-flight write here.
   assign byp_hit  = (write_rg_q != 5'd0) && (byp_rg == write_rg_q);
   assign byp_data = write_data_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: scoreboard of expected writebacks plus a small
// grant / pending-mask model; a second instance covers the fixed-priority build.
module tb_wb_arbiter;

   localparam int XLEN = 32;

   typedef struct packed {
      logic            v;
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            alu_valid = 1'b0, mem_valid = 1'b0, issue_valid = 1'b0;
   logic [4:0]      alu_rd = '0, mem_rd = '0, issue_rd = '0;
   logic [XLEN-1:0] alu_data = '0, mem_data = '0;
   logic            alu_ready, mem_ready, fp_alu_ready, fp_mem_ready;
   logic [4:0]      write_rg, fp_write_rg;
   logic [XLEN-1:0] write_data, fp_write_data;
   logic [31:0]     pend_mask, fp_pend_mask;
`ifdef WB_BYPASS_EN
   logic [4:0]      byp_rg = '0;
   logic            byp_hit, fp_byp_hit;
   logic [XLEN-1:0] byp_data, fp_byp_data;
`endif

   int   vectors = 0;
   int   miscompares = 0;
   exp_t exp_q[$];
   logic last_mem_m;      // model of last_grant: 1 = MEM
   logic [31:0] pend_m;

   always #5 clk = ~clk;

   wb_arbiter #(.FIXED_PRIO(1'b0), .XLEN(XLEN)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .write_rg(write_rg), .write_data(write_data),
`ifdef WB_BYPASS_EN
      .byp_rg(byp_rg), .byp_hit(byp_hit), .byp_data(byp_data),
`endif
      .pend_mask(pend_mask)
   );

   wb_arbiter #(.FIXED_PRIO(1'b1), .XLEN(XLEN)) dut_fp (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(fp_alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(fp_mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .write_rg(fp_write_rg), .write_data(fp_write_data),
`ifdef WB_BYPASS_EN
      .byp_rg(byp_rg), .byp_hit(fp_byp_hit), .byp_data(fp_byp_data),
`endif
      .pend_mask(fp_pend_mask)
   );

   task automatic model_reset();
      last_mem_m = 1'b1;
      pend_m     = '0;
      exp_q.delete();
   endtask

   // One clock: check readies against the model, push the expected writeback, clock,
   // then pop and compare the write port and pending mask.
   task automatic step(output logic ga, output logic gm);
      exp_t e;
      ga = 1'b0;
      gm = 1'b0;
      #1;
      if (alu_valid && mem_valid) begin
         if (last_mem_m) ga = 1'b1;
         else            gm = 1'b1;
      end else begin
         ga = alu_valid;
         gm = mem_valid;
      end
      vectors++;
      if ({alu_ready, mem_ready} !== {ga, gm}) begin
         miscompares++;
         $display("FAIL ready: got alu=%b mem=%b expected alu=%b mem=%b", alu_ready, mem_ready, ga, gm);
      end
      if (ga)      e = '{v: 1'b1, rd: alu_rd, data: alu_data};
      else if (gm) e = '{v: 1'b1, rd: mem_rd, data: mem_data};
      else         e = '{v: 1'b0, rd: 5'd0, data: '0};
      exp_q.push_back(e);
      if (alu_valid && mem_valid) last_mem_m = gm;
      if (ga) pend_m[alu_rd] = 1'b0;
      if (gm) pend_m[mem_rd] = 1'b0;
      if (issue_valid && issue_rd != 5'd0) pend_m[issue_rd] = 1'b1;
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      vectors++;
      if (write_rg !== e.rd) begin
         miscompares++;
         $display("FAIL write_rg: got %0d expected %0d", write_rg, e.rd);
      end
      if (e.v && e.rd != 5'd0) begin
         vectors++;
         if (write_data !== e.data) begin
            miscompares++;
            $display("FAIL write_data: got %h expected %h", write_data, e.data);
         end
      end
      vectors++;
      if (pend_mask !== pend_m) begin
         miscompares++;
         $display("FAIL pend_mask: got %h expected %h", pend_mask, pend_m);
      end
   endtask

   task automatic test_reset();
      rst       = 1'b0;
      alu_valid = 1'b1;
      mem_valid = 1'b1;
      model_reset();
      #12;
      vectors++;
      if ({write_rg, write_data, pend_mask, alu_ready, mem_ready} !== '0) begin
         miscompares++;
         $display("FAIL reset_state: got rg=%0d data=%h pend=%h rdy=%b%b expected all zero",
                  write_rg, write_data, pend_mask, alu_ready, mem_ready);
      end
      alu_valid = 1'b0;
      mem_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_single_alu();
      logic ga, gm;
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_00AA;
      step(ga, gm);
      alu_valid = 1'b0;
      step(ga, gm);
      // rd=0 transfer: accepted, nothing written
      mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h1234_5678;
      step(ga, gm);
      mem_valid = 1'b0;
      step(ga, gm);
   endtask

   task automatic test_round_robin();
      logic ga, gm;
      logic [4:0] wins[$];
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA000_0000;
      mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'hB000_0000;
      for (int i = 0; i < 5; i++) begin
         step(ga, gm);
         wins.push_back(ga ? alu_rd : mem_rd);
         if (ga) alu_data = alu_data + 32'd1;
         if (gm) mem_data = mem_data + 32'd1;
      end
      alu_valid = 1'b0;
      mem_valid = 1'b0;
      step(ga, gm);
      // First contention after reset goes to ALU, then strict alternation.
      vectors++;
      if (wins.size() != 5 || wins[0] != 5'd1 || wins[1] != 5'd2 || wins[2] != 5'd1 ||
          wins[3] != 5'd2 || wins[4] != 5'd1) begin
         miscompares++;
         $display("FAIL rr_sequence: got %p expected '{1,2,1,2,1}", wins);
      end
   endtask

   task automatic test_fixed_prio();
      logic ga, gm;
      logic [XLEN-1:0] alu_hold;
      alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hCAFE_0011;
      mem_valid = 1'b1; mem_rd = 5'd4;  mem_data = 32'h4444_0000;
      alu_hold  = alu_data;
      for (int i = 0; i < 3; i++) begin
         #1;
         vectors++;
         if ({fp_alu_ready, fp_mem_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL fp_ready: got alu=%b mem=%b expected alu=0 mem=1", fp_alu_ready, fp_mem_ready);
         end
         step(ga, gm);
         vectors++;
         if (fp_write_rg !== 5'd4 || fp_write_data !== 32'h4444_0000 + XLEN'(i)) begin
            miscompares++;
            $display("FAIL fp_write: got rg=%0d data=%h expected rg=4 data=%h",
                     fp_write_rg, fp_write_data, 32'h4444_0000 + XLEN'(i));
         end
         if (ga) alu_data = alu_data + 32'd1;
         mem_data = mem_data + 32'd1;
      end
      mem_valid = 1'b0;
      step(ga, gm);
      alu_valid = 1'b0;
      step(ga, gm);
      vectors++;
      if (alu_hold === alu_data) begin
         miscompares++;
         $display("FAIL fp_alu_starved_check: main instance never granted ALU, data=%h", alu_data);
      end
   endtask

   task automatic test_scoreboard();
      logic ga, gm;
      issue_valid = 1'b1; issue_rd = 5'd7;
      step(ga, gm);
      vectors++;
      if (pend_mask !== 32'h0000_0080) begin
         miscompares++;
         $display("FAIL pend_issue7: got %h expected 00000080", pend_mask);
      end
      issue_valid = 1'b0;
      step(ga, gm);
      mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h7777_7777;
      issue_valid = 1'b1; issue_rd = 5'd7;
      step(ga, gm);
      vectors++;
      if (pend_mask[7] !== 1'b1) begin
         miscompares++;
         $display("FAIL pend_set_wins: got bit7=%b expected 1", pend_mask[7]);
      end
      mem_valid = 1'b0;
      issue_rd  = 5'd0;
      step(ga, gm);
      vectors++;
      if (pend_mask[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL pend_bit0: got %b expected 0", pend_mask[0]);
      end
      issue_valid = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h0707_0707;
      step(ga, gm);
      alu_valid = 1'b0;
      step(ga, gm);
   endtask

`ifdef WB_BYPASS_EN
   task automatic test_bypass();
      logic ga, gm;
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hFEED_FEED;
      step(ga, gm);
      alu_valid = 1'b0;
      byp_rg = 5'd3;
      #1;
      vectors++;
      if (byp_hit !== 1'b1 || byp_data !== 32'hFEED_FEED) begin
         miscompares++;
         $display("FAIL byp_hit3: got hit=%b data=%h expected hit=1 data=feedfeed", byp_hit, byp_data);
      end
      byp_rg = 5'd4;
      #1;
      vectors++;
      if (byp_hit !== 1'b0) begin
         miscompares++;
         $display("FAIL byp_miss4: got hit=%b expected 0", byp_hit);
      end
      step(ga, gm);
      byp_rg = 5'd3;
      #1;
      vectors++;
      if (byp_hit !== 1'b0) begin
         miscompares++;
         $display("FAIL byp_idle: got hit=%b expected 0", byp_hit);
      end
   endtask
`endif

   task automatic test_reset_mid_op();
      logic ga, gm;
      issue_valid = 1'b1; issue_rd = 5'd9;
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h9999_0009;
      step(ga, gm);
      issue_valid = 1'b0;
      vectors++;
      if (write_rg !== 5'd9 || pend_mask !== 32'h0000_0200) begin
         miscompares++;
         $display("FAIL premise_reset: got rg=%0d pend=%h expected rg=9 pend=00000200", write_rg, pend_mask);
      end
      #1;
      rst = 1'b0;
      #1;
      vectors++;
      if (write_rg !== 5'd0 || pend_mask !== 32'h0 || alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset: got rg=%0d pend=%h rdy=%b%b expected 0 0 00",
                  write_rg, pend_mask, alu_ready, mem_ready);
      end
      alu_valid = 1'b0;
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      step(ga, gm);
   endtask

   initial begin
      test_reset();
      test_single_alu();
      test_round_robin();
      test_fixed_prio();
      test_scoreboard();
`ifdef WB_BYPASS_EN
      test_bypass();
`endif
      test_reset_mid_op();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish within 100000 time units");
      $fatal(1, "timeout");
   end

endmodule
